// File: rtl/dot_prod_lag_ctrl_if.sv
// Bus bundle between the lag-sweep controller and its environment: sweep
// control, sample-buffer addressing, the dot_prod_pip stream handshakes and
// the downstream lag-result stream. Signal suffixes are from the controller's
// point of view (_i into the controller, _o out of it).
interface dot_prod_lag_ctrl_if #(
   parameter int ADDR_BITS  = 6,
   parameter int LAG_BITS   = 3,
   parameter int SUM_I_SIZE = 30,
   parameter int SUM_Q_SIZE = 30
);
   logic                  start_i;
   logic                  busy_o;
   logic                  done_o;
   logic [ADDR_BITS-1:0]  x_addr_o;
   logic [ADDR_BITS-1:0]  y_addr_o;
   logic                  m_axis_x_tvalid_o;
   logic                  m_axis_y_tvalid_o;
   logic                  s_axis_product_tvalid_i;
   logic                  m_axis_product_tready_o;
   logic [SUM_I_SIZE-1:0] i_i;
   logic [SUM_Q_SIZE-1:0] q_i;
   logic                  s_axis_lag_tvalid_o;
   logic                  m_axis_lag_tready_i;
   logic [SUM_I_SIZE-1:0] lag_i_o;
   logic [SUM_Q_SIZE-1:0] lag_q_o;
   logic [LAG_BITS-1:0]   lag_index_o;

   // Controller side: drives addresses, stream valids and lag results.
   modport master (
      input  start_i,
      output busy_o,
      output done_o,
      output x_addr_o,
      output y_addr_o,
      output m_axis_x_tvalid_o,
      output m_axis_y_tvalid_o,
      input  s_axis_product_tvalid_i,
      output m_axis_product_tready_o,
      input  i_i,
      input  q_i,
      output s_axis_lag_tvalid_o,
      input  m_axis_lag_tready_i,
      output lag_i_o,
      output lag_q_o,
      output lag_index_o
   );

   // Environment side: buffers, dot_prod_pip and the downstream consumer.
   modport slave (
      output start_i,
      input  busy_o,
      input  done_o,
      input  x_addr_o,
      input  y_addr_o,
      input  m_axis_x_tvalid_o,
      input  m_axis_y_tvalid_o,
      output s_axis_product_tvalid_i,
      input  m_axis_product_tready_o,
      output i_i,
      output q_i,
      input  s_axis_lag_tvalid_o,
      output m_axis_lag_tready_i,
      input  lag_i_o,
      input  lag_q_o,
      input  lag_index_o
   );
endinterface

// File: rtl/dot_prod_lag_ctrl.sv
// Lag-sweep sequencer for the CAF path. For each lag k it streams x[n] and
// y[n+k] (n = 0..LENGTH-1) from two 1-cycle-latency sample buffers into
// dot_prod_pip, waits for the single product, and presents it downstream
// tagged with k. Only one dot product is in flight; the next lag streams
// only after the previous result has been consumed.
module dot_prod_lag_ctrl #(
   parameter int LENGTH        = 16,
   parameter int BUFFER_LENGTH = 64,
   parameter int NUM_LAGS      = 8,
   parameter int SUM_I_SIZE    = 30,
   parameter int SUM_Q_SIZE    = 30
) (
   input  logic                clk_i,
   input  logic                reset_i,
   dot_prod_lag_ctrl_if.master bus
);
   localparam int ADDR_BITS = $clog2(BUFFER_LENGTH);
   localparam int LAG_BITS  = (NUM_LAGS > 1) ? $clog2(NUM_LAGS) : 1;
   localparam int CNT_BITS  = (LENGTH > 1) ? $clog2(LENGTH) : 1;
   localparam logic [CNT_BITS-1:0] N_LAST = CNT_BITS'(LENGTH - 1);
   localparam logic [LAG_BITS-1:0] K_LAST = LAG_BITS'(NUM_LAGS - 1);

   // The largest y address (NUM_LAGS-2+LENGTH) must stay inside the buffer.
   generate
      if (NUM_LAGS - 1 + LENGTH > BUFFER_LENGTH) begin : g_len_check
         $error("dot_prod_lag_ctrl: NUM_LAGS-1+LENGTH exceeds BUFFER_LENGTH");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_STREAM    = 2'd1,
      ST_WAIT_PROD = 2'd2,
      ST_OUTPUT    = 2'd3
   } state_t;

   state_t                 state_q;
   logic [CNT_BITS-1:0]    n_q;
   logic [LAG_BITS-1:0]    k_q;
   logic [ADDR_BITS-1:0]   x_addr_q;
   logic [ADDR_BITS-1:0]   y_addr_q;
   logic                   busy_q;
   logic                   done_q;
   logic                   x_tvalid_q;
   logic                   y_tvalid_q;
   logic                   prod_tready_q;
   logic                   lag_tvalid_q;
   logic [SUM_I_SIZE-1:0]  lag_i_q;
   logic [SUM_Q_SIZE-1:0]  lag_q_q;
   logic [LAG_BITS-1:0]    lag_index_q;

   logic [CNT_BITS-1:0]    n_d;
   logic [LAG_BITS-1:0]    k_d;
   logic [ADDR_BITS-1:0]   x_addr_d;
   logic [ADDR_BITS-1:0]   y_addr_d;
   logic [ADDR_BITS-1:0]   y_base_d;
   logic                   prod_hs_s;
   logic                   lag_hs_s;

   // Next sample/lag counters, their buffer addresses and the two handshakes.
   always_comb begin
      n_d       = n_q + CNT_BITS'(1);
      k_d       = k_q + LAG_BITS'(1);
      x_addr_d  = ADDR_BITS'(n_d);
      y_addr_d  = ADDR_BITS'(k_q) + ADDR_BITS'(n_d);
      y_base_d  = ADDR_BITS'(k_d);
      prod_hs_s = bus.s_axis_product_tvalid_i & prod_tready_q;
      lag_hs_s  = lag_tvalid_q & bus.m_axis_lag_tready_i;
   end

   // Sweep FSM: state, counters, addresses and every registered output.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q       <= ST_IDLE;
         n_q           <= '0;
         k_q           <= '0;
         x_addr_q      <= '0;
         y_addr_q      <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         x_tvalid_q    <= 1'b0;
         y_tvalid_q    <= 1'b0;
         prod_tready_q <= 1'b0;
         lag_tvalid_q  <= 1'b0;
         lag_i_q       <= '0;
         lag_q_q       <= '0;
         lag_index_q   <= '0;
      end else begin
         done_q     <= 1'b0;
         // Buffer data appears one cycle after its address, so the stream
         // valids are the STREAM state delayed by one cycle.
         x_tvalid_q <= (state_q == ST_STREAM);
         y_tvalid_q <= (state_q == ST_STREAM);
         case (state_q)
            ST_IDLE: begin
               if (bus.start_i) begin
                  state_q  <= ST_STREAM;
                  busy_q   <= 1'b1;
                  n_q      <= '0;
                  k_q      <= '0;
                  x_addr_q <= '0;
                  y_addr_q <= '0;
               end
            end
            ST_STREAM: begin
               if (n_q == N_LAST) begin
                  state_q       <= ST_WAIT_PROD;
                  prod_tready_q <= 1'b1;
               end else begin
                  n_q      <= n_d;
                  x_addr_q <= x_addr_d;
                  y_addr_q <= y_addr_d;
               end
            end
            ST_WAIT_PROD: begin
               // No latency is assumed for dot_prod_pip; wait as long as needed.
               if (prod_hs_s) begin
                  lag_i_q       <= bus.i_i;
                  lag_q_q       <= bus.q_i;
                  lag_index_q   <= k_q;
                  prod_tready_q <= 1'b0;
                  lag_tvalid_q  <= 1'b1;
                  state_q       <= ST_OUTPUT;
               end
            end
            ST_OUTPUT: begin
               if (lag_hs_s) begin
                  lag_tvalid_q <= 1'b0;
                  if (k_q != K_LAST) begin
                     k_q      <= k_d;
                     n_q      <= '0;
                     x_addr_q <= '0;
                     y_addr_q <= y_base_d;
                     state_q  <= ST_STREAM;
                  end else begin
                     state_q <= ST_IDLE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end
               end
            end
            default: begin
               state_q       <= ST_IDLE;
               busy_q        <= 1'b0;
               prod_tready_q <= 1'b0;
               lag_tvalid_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy_o                  = busy_q;
   assign bus.done_o                  = done_q;
   assign bus.x_addr_o                = x_addr_q;
   assign bus.y_addr_o                = y_addr_q;
   assign bus.m_axis_x_tvalid_o       = x_tvalid_q;
   assign bus.m_axis_y_tvalid_o       = y_tvalid_q;
   assign bus.m_axis_product_tready_o = prod_tready_q;
   assign bus.s_axis_lag_tvalid_o     = lag_tvalid_q;
   assign bus.lag_i_o                 = lag_i_q;
   assign bus.lag_q_o                 = lag_q_q;
   assign bus.lag_index_o             = lag_index_q;

endmodule

// File: tb/tb_dot_prod_lag_ctrl.sv
// Directed bench for dot_prod_lag_ctrl: behavioural sample buffers and a
// dot_prod_pip stand-in feed the controller; each scenario task compares the
// outputs against hand-computed closed-form values.
`timescale 1ns/1ps
module tb_dot_prod_lag_ctrl;
   localparam int LENGTH        = 16;
   localparam int BUFFER_LENGTH = 64;
   localparam int NUM_LAGS      = 8;
   localparam int SUM_I_SIZE    = 30;
   localparam int SUM_Q_SIZE    = 30;
   localparam int ADDR_BITS     = 6;
   localparam int LAG_BITS      = 3;
   localparam int LOG_DEPTH     = 4096;
   localparam int MAX_BURSTS    = 128;
   localparam int PROD_LATENCY  = 3;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   dot_prod_lag_ctrl_if #(
      .ADDR_BITS(ADDR_BITS), .LAG_BITS(LAG_BITS),
      .SUM_I_SIZE(SUM_I_SIZE), .SUM_Q_SIZE(SUM_Q_SIZE)
   ) bus ();

   dot_prod_lag_ctrl #(
      .LENGTH(LENGTH), .BUFFER_LENGTH(BUFFER_LENGTH), .NUM_LAGS(NUM_LAGS),
      .SUM_I_SIZE(SUM_I_SIZE), .SUM_Q_SIZE(SUM_Q_SIZE)
   ) dut (
      .clk_i   (clk),
      .reset_i (reset),
      .bus     (bus)
   );

   int checks = 0;
   int errors = 0;

   // ---------------- sample buffers and dot_prod_pip stand-in ----------------
   int x_re [BUFFER_LENGTH];
   int x_im [BUFFER_LENGTH];
   int y_re [BUFFER_LENGTH];
   int y_im [BUFFER_LENGTH];
   int x_rd_re, x_rd_im, y_rd_re, y_rd_im;
   int acc_i, acc_q, pend_i, pend_q, samp_cnt, lat;
   int p_i, p_q;

   // product of x with conj(y) for the sample pair currently on the stream
   assign p_i = x_rd_re * y_rd_re + x_rd_im * y_rd_im;
   assign p_q = x_rd_im * y_rd_re - x_rd_re * y_rd_im;

   // 1-cycle buffers plus accumulate-and-emit product model
   always @(posedge clk) begin
      x_rd_re <= x_re[bus.x_addr_o];
      x_rd_im <= x_im[bus.x_addr_o];
      y_rd_re <= y_re[bus.y_addr_o];
      y_rd_im <= y_im[bus.y_addr_o];
      if (reset) begin
         acc_i <= 0; acc_q <= 0; samp_cnt <= 0; lat <= 0;
         pend_i <= 0; pend_q <= 0;
         bus.s_axis_product_tvalid_i <= 1'b0;
         bus.i_i <= '0;
         bus.q_i <= '0;
      end else begin
         if (bus.s_axis_product_tvalid_i && bus.m_axis_product_tready_o)
            bus.s_axis_product_tvalid_i <= 1'b0;
         if (lat != 0) begin
            lat <= lat - 1;
            if (lat == 1) begin
               bus.s_axis_product_tvalid_i <= 1'b1;
               bus.i_i <= SUM_I_SIZE'(pend_i);
               bus.q_i <= SUM_Q_SIZE'(pend_q);
            end
         end
         if (bus.m_axis_x_tvalid_o && bus.m_axis_y_tvalid_o) begin
            if (samp_cnt == LENGTH - 1) begin
               pend_i <= acc_i + p_i;
               pend_q <= acc_q + p_q;
               acc_i <= 0; acc_q <= 0; samp_cnt <= 0;
               lat <= PROD_LATENCY;
            end else begin
               acc_i <= acc_i + p_i;
               acc_q <= acc_q + p_q;
               samp_cnt <= samp_cnt + 1;
            end
         end
      end
   end

   // ---------------- address / valid log and burst tracker ----------------
   logic [ADDR_BITS-1:0] x_log [LOG_DEPTH];
   logic [ADDR_BITS-1:0] y_log [LOG_DEPTH];
   logic                 tvx_log [LOG_DEPTH];
   logic                 tvy_log [LOG_DEPTH];
   int   b_start [MAX_BURSTS];
   int   b_len   [MAX_BURSTS];
   int   cyc = 0;
   int   bcnt = 0;
   int   cur_len = 0;
   logic tv_prev = 1'b0;

   // record what was presented during each cycle and where tvalid bursts lie
   always @(posedge clk) begin
      x_log[cyc]   <= bus.x_addr_o;
      y_log[cyc]   <= bus.y_addr_o;
      tvx_log[cyc] <= bus.m_axis_x_tvalid_o;
      tvy_log[cyc] <= bus.m_axis_y_tvalid_o;
      if (cyc < LOG_DEPTH - 1) cyc <= cyc + 1;
      tv_prev <= bus.m_axis_x_tvalid_o;
      if (bus.m_axis_x_tvalid_o && !tv_prev) begin
         b_start[bcnt] <= cyc;
         cur_len <= 1;
      end else if (bus.m_axis_x_tvalid_o) begin
         cur_len <= cur_len + 1;
      end else if (tv_prev) begin
         b_len[bcnt] <= cur_len;
         if (bcnt < MAX_BURSTS - 1) bcnt <= bcnt + 1;
      end
   end

   // ---------------- sweep results ----------------
   logic [SUM_I_SIZE-1:0] res_i [NUM_LAGS];
   logic [SUM_Q_SIZE-1:0] res_q [NUM_LAGS];
   logic [LAG_BITS-1:0]   res_k [NUM_LAGS];
   int nres;
   int sweep_base;

   // mode 0: x=y=1+0j; mode 1: x[n]=y[n]=n; mode 2: x[n]=n+1j, y[n]=n
   task automatic load_data(input int mode);
      for (int a = 0; a < BUFFER_LENGTH; a++) begin
         x_re[a] = (mode == 0) ? 1 : a;
         x_im[a] = (mode == 2) ? 1 : 0;
         y_re[a] = (mode == 0) ? 1 : a;
         y_im[a] = 0;
      end
   endtask

   // sum n^2 (n=0..15) = 1240, sum n = 120
   function automatic int exp_i(input int mode, input int k);
      if (mode == 0) return LENGTH;
      return 1240 + 120 * k;
   endfunction

   function automatic int exp_q(input int mode, input int k);
      if (mode == 2) return 120 + 16 * k;
      return 0;
   endfunction

   // One full sweep; optionally stalls the result at hold_lag for 20 cycles
   // and/or pulses start while busy. Returns one cycle after done.
   task automatic run_sweep(input int hold_lag, input bit spam);
      int hold;
      bit fin;
      bit ready;
      logic [SUM_I_SIZE-1:0] h_i;
      logic [SUM_Q_SIZE-1:0] h_q;
      logic [LAG_BITS-1:0]   h_k;
      logic [ADDR_BITS-1:0]  h_y;
      nres = 0; hold = 0; fin = 1'b0;
      h_i = '0; h_q = '0; h_k = '0; h_y = '0;
      sweep_base = bcnt;
      bus.m_axis_lag_tready_i = 1'b1;
      bus.start_i = 1'b1;
      @(negedge clk);
      bus.start_i = 1'b0;
      checks++;
      if (bus.busy_o !== 1'b1) begin
         errors++; $display("FAIL busy_after_start: got %b want 1", bus.busy_o);
      end
      for (int t = 0; t < 3000 && !fin; t++) begin
         if (bus.done_o === 1'b1) begin
            fin = 1'b1;
         end else begin
            bus.start_i = spam && (bus.busy_o === 1'b1) && (t % 7 == 3);
            ready = 1'b1;
            if (bus.s_axis_lag_tvalid_o === 1'b1 && int'(bus.lag_index_o) == hold_lag && hold < 20) begin
               ready = 1'b0;
               if (hold == 0) begin
                  h_i = bus.lag_i_o; h_q = bus.lag_q_o; h_k = bus.lag_index_o; h_y = bus.y_addr_o;
               end else begin
                  checks++;
                  if (bus.lag_i_o !== h_i || bus.lag_q_o !== h_q || bus.lag_index_o !== h_k) begin
                     errors++; $display("FAIL hold_stable: got i=%0d q=%0d k=%0d want i=%0d q=%0d k=%0d",
                        bus.lag_i_o, bus.lag_q_o, bus.lag_index_o, h_i, h_q, h_k);
                  end
                  checks++;
                  if (bus.m_axis_x_tvalid_o !== 1'b0 || bus.y_addr_o !== h_y) begin
                     errors++; $display("FAIL hold_no_stream: got tvalid=%b y_addr=%0d want tvalid=0 y_addr=%0d",
                        bus.m_axis_x_tvalid_o, bus.y_addr_o, h_y);
                  end
               end
               hold++;
            end
            bus.m_axis_lag_tready_i = ready;
            if (bus.s_axis_lag_tvalid_o === 1'b1 && ready) begin
               if (nres < NUM_LAGS) begin
                  res_i[nres] = bus.lag_i_o; res_q[nres] = bus.lag_q_o; res_k[nres] = bus.lag_index_o;
               end
               nres++;
            end
            @(negedge clk);
         end
      end
      bus.start_i = 1'b0;
      bus.m_axis_lag_tready_i = 1'b1;
      checks++;
      if (!fin) begin errors++; $display("FAIL sweep_timeout: got no done want done"); end
      if (hold_lag >= 0) begin
         checks++;
         if (hold != 20) begin errors++; $display("FAIL hold_cycles: got %0d want 20", hold); end
      end
      checks++;
      if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL busy_at_done: got %b want 0", bus.busy_o); end
      @(negedge clk);
      checks++;
      if (bus.done_o !== 1'b0) begin errors++; $display("FAIL done_width: got %b want 0", bus.done_o); end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.start_i = 1'b0;
      bus.m_axis_lag_tready_i = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.busy_o, bus.done_o, bus.m_axis_x_tvalid_o, bus.m_axis_y_tvalid_o,
           bus.m_axis_product_tready_o, bus.s_axis_lag_tvalid_o} !== 6'b000000) begin
         errors++; $display("FAIL reset_flags: got %b want 000000", {bus.busy_o, bus.done_o,
            bus.m_axis_x_tvalid_o, bus.m_axis_y_tvalid_o, bus.m_axis_product_tready_o, bus.s_axis_lag_tvalid_o});
      end
      checks++;
      if (bus.x_addr_o !== 6'd0 || bus.y_addr_o !== 6'd0 || bus.lag_i_o !== 30'd0 ||
          bus.lag_q_o !== 30'd0 || bus.lag_index_o !== 3'd0) begin
         errors++; $display("FAIL reset_data: got x=%0d y=%0d i=%0d q=%0d k=%0d want all 0",
            bus.x_addr_o, bus.y_addr_o, bus.lag_i_o, bus.lag_q_o, bus.lag_index_o);
      end
      reset = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (bus.busy_o !== 1'b0 || bus.m_axis_x_tvalid_o !== 1'b0) begin
         errors++; $display("FAIL idle_no_start: got busy=%b tvalid=%b want 0 0", bus.busy_o, bus.m_axis_x_tvalid_o);
      end
   endtask

   task automatic test_sweep_basic();
      load_data(2);
      run_sweep(-1, 1'b0);
      checks++;
      if (nres != NUM_LAGS) begin errors++; $display("FAIL basic_count: got %0d want %0d", nres, NUM_LAGS); end
      for (int k = 0; k < NUM_LAGS; k++) begin
         checks++;
         if (res_k[k] !== LAG_BITS'(k) || res_i[k] !== SUM_I_SIZE'(exp_i(2, k)) || res_q[k] !== SUM_Q_SIZE'(exp_q(2, k))) begin
            errors++; $display("FAIL basic_lag%0d: got k=%0d i=%0d q=%0d want k=%0d i=%0d q=%0d",
               k, res_k[k], res_i[k], res_q[k], k, exp_i(2, k), exp_q(2, k));
         end
         checks++;
         if (b_len[sweep_base + k] != LENGTH) begin
            errors++; $display("FAIL basic_burst%0d: got %0d want %0d", k, b_len[sweep_base + k], LENGTH);
         end
      end
   endtask

   // Examines the lag-3 burst of the most recent sweep in the cycle log.
   task automatic test_lag3_addresses();
      int c;
      c = b_start[sweep_base + 3];
      if (c < 2) c = 2;
      if (c > LOG_DEPTH - 20) c = LOG_DEPTH - 20;
      checks++;
      if (tvx_log[c - 1] !== 1'b0 || tvy_log[c - 1] !== 1'b0) begin
         errors++; $display("FAIL lag3_pre_valid: got x=%b y=%b want 0 0", tvx_log[c - 1], tvy_log[c - 1]);
      end
      for (int j = 0; j < LENGTH; j++) begin
         checks++;
         if (x_log[c - 1 + j] !== ADDR_BITS'(j) || y_log[c - 1 + j] !== ADDR_BITS'(3 + j)) begin
            errors++; $display("FAIL lag3_addr%0d: got x=%0d y=%0d want x=%0d y=%0d",
               j, x_log[c - 1 + j], y_log[c - 1 + j], j, 3 + j);
         end
         checks++;
         if (tvx_log[c + j] !== 1'b1 || tvy_log[c + j] !== 1'b1) begin
            errors++; $display("FAIL lag3_valid%0d: got x=%b y=%b want 1 1", j, tvx_log[c + j], tvy_log[c + j]);
         end
      end
      checks++;
      if (tvx_log[c + LENGTH] !== 1'b0 || tvy_log[c + LENGTH] !== 1'b0) begin
         errors++; $display("FAIL lag3_post_valid: got x=%b y=%b want 0 0", tvx_log[c + LENGTH], tvy_log[c + LENGTH]);
      end
   endtask

   task automatic test_data_patterns();
      for (int m = 0; m < 2; m++) begin
         load_data(m);
         run_sweep(-1, 1'b0);
         checks++;
         if (nres != NUM_LAGS) begin errors++; $display("FAIL pattern%0d_count: got %0d want %0d", m, nres, NUM_LAGS); end
         for (int k = 0; k < NUM_LAGS; k++) begin
            checks++;
            if (res_i[k] !== SUM_I_SIZE'(exp_i(m, k)) || res_q[k] !== SUM_Q_SIZE'(exp_q(m, k))) begin
               errors++; $display("FAIL pattern%0d_lag%0d: got i=%0d q=%0d want i=%0d q=%0d",
                  m, k, res_i[k], res_q[k], exp_i(m, k), exp_q(m, k));
            end
         end
      end
   endtask

   task automatic test_backpressure();
      load_data(2);
      run_sweep(2, 1'b0);
      checks++;
      if (nres != NUM_LAGS) begin errors++; $display("FAIL bp_count: got %0d want %0d", nres, NUM_LAGS); end
      for (int k = 0; k < NUM_LAGS; k++) begin
         checks++;
         if (res_k[k] !== LAG_BITS'(k) || res_i[k] !== SUM_I_SIZE'(exp_i(2, k))) begin
            errors++; $display("FAIL bp_lag%0d: got k=%0d i=%0d want k=%0d i=%0d", k, res_k[k], res_i[k], k, exp_i(2, k));
         end
      end
   endtask

   task automatic test_start_during_busy();
      load_data(1);
      run_sweep(-1, 1'b1);
      checks++;
      if (nres != NUM_LAGS) begin errors++; $display("FAIL spam_count: got %0d want %0d", nres, NUM_LAGS); end
      for (int k = 0; k < NUM_LAGS; k++) begin
         checks++;
         if (res_k[k] !== LAG_BITS'(k) || res_i[k] !== SUM_I_SIZE'(exp_i(1, k))) begin
            errors++; $display("FAIL spam_lag%0d: got k=%0d i=%0d want k=%0d i=%0d", k, res_k[k], res_i[k], k, exp_i(1, k));
         end
      end
   endtask

   task automatic test_reset_in_stream();
      bus.start_i = 1'b1;
      @(negedge clk);
      bus.start_i = 1'b0;
      repeat (5) @(negedge clk);
      checks++;
      if (bus.m_axis_x_tvalid_o !== 1'b1) begin
         errors++; $display("FAIL rst_stream_active: got %b want 1", bus.m_axis_x_tvalid_o);
      end
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if ({bus.busy_o, bus.m_axis_x_tvalid_o, bus.m_axis_y_tvalid_o,
           bus.m_axis_product_tready_o, bus.s_axis_lag_tvalid_o} !== 5'b00000) begin
         errors++; $display("FAIL rst_stream_flags: got %b want 00000", {bus.busy_o, bus.m_axis_x_tvalid_o,
            bus.m_axis_y_tvalid_o, bus.m_axis_product_tready_o, bus.s_axis_lag_tvalid_o});
      end
      checks++;
      if (bus.x_addr_o !== 6'd0 || bus.y_addr_o !== 6'd0) begin
         errors++; $display("FAIL rst_stream_addr: got x=%0d y=%0d want 0 0", bus.x_addr_o, bus.y_addr_o);
      end
      reset = 1'b0;
      repeat (30) @(negedge clk);
      checks++;
      if (bus.busy_o !== 1'b0 || bus.s_axis_lag_tvalid_o !== 1'b0 || bus.m_axis_x_tvalid_o !== 1'b0) begin
         errors++; $display("FAIL rst_stream_idle: got busy=%b lagv=%b tv=%b want 0 0 0",
            bus.busy_o, bus.s_axis_lag_tvalid_o, bus.m_axis_x_tvalid_o);
      end
   endtask

   task automatic test_back_to_back();
      logic [SUM_I_SIZE-1:0] r1_i [NUM_LAGS];
      logic [SUM_Q_SIZE-1:0] r1_q [NUM_LAGS];
      int n1;
      load_data(2);
      run_sweep(-1, 1'b0);
      n1 = nres;
      for (int k = 0; k < NUM_LAGS; k++) begin
         r1_i[k] = res_i[k]; r1_q[k] = res_q[k];
      end
      run_sweep(-1, 1'b0);
      checks++;
      if (nres != n1 || nres != NUM_LAGS) begin
         errors++; $display("FAIL b2b_count: got %0d/%0d want %0d", n1, nres, NUM_LAGS);
      end
      for (int k = 0; k < NUM_LAGS; k++) begin
         checks++;
         if (res_i[k] !== r1_i[k] || res_q[k] !== r1_q[k] || res_i[k] !== SUM_I_SIZE'(exp_i(2, k)) ||
             res_q[k] !== SUM_Q_SIZE'(exp_q(2, k))) begin
            errors++; $display("FAIL b2b_lag%0d: got i=%0d q=%0d first i=%0d q=%0d want i=%0d q=%0d",
               k, res_i[k], res_q[k], r1_i[k], r1_q[k], exp_i(2, k), exp_q(2, k));
         end
         checks++;
         if (b_len[sweep_base + k] != LENGTH) begin
            errors++; $display("FAIL b2b_burst%0d: got %0d want %0d", k, b_len[sweep_base + k], LENGTH);
         end
      end
   endtask

   initial begin
      test_reset();
      test_sweep_basic();
      test_lag3_addresses();
      test_data_patterns();
      test_backpressure();
      test_start_during_busy();
      test_reset_in_stream();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
